// File: rtl/game_state_controller_if.sv
// Signal bundle between the frog controller side and the game-flow controller.
// The controller takes the slave modport; the frog side/bench takes master.
interface game_state_controller_if;
    logic       frog_at_top;
    logic       collision_detected;
    logic [1:0] lives;
    logic       restart;
    logic       reset_frog;
    logic       reset_lives;
    logic [3:0] level;
    logic [3:0] best_level;
    logic       level_up;
    logic       freeze;
    logic       game_over;

    modport master (
        output frog_at_top, collision_detected, lives, restart,
        input  reset_frog, reset_lives, level, best_level, level_up, freeze, game_over
    );

    modport slave (
        input  frog_at_top, collision_detected, lives, restart,
        output reset_frog, reset_lives, level, best_level, level_up, freeze, game_over
    );
endinterface

// File: rtl/game_state_controller.sv
// Game-flow FSM: level progression, death/level pauses, game-over hold and restart.
//  state         | meaning
//  S_INIT        | one cycle; issues reset_frog/reset_lives, level back to 1
//  S_PLAY        | normal play; watches lives, frog_at_top, collision edge
//  S_LEVEL_PAUSE | freeze after a level-up, timer counts down
//  S_DEATH_PAUSE | freeze after a collision, timer counts down
//  S_GAME_OVER   | game_over/freeze held, timer counts down then restarts
module game_state_controller #(
    parameter int MAX_LEVEL       = 9,
    parameter int PAUSE_CYCLES    = 25_000_000,
    parameter int GAMEOVER_CYCLES = 75_000_000,
    parameter int TIMER_W         = 27
) (
    input logic                    clk,
    input logic                    reset,
    game_state_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT, S_PLAY, S_LEVEL_PAUSE, S_DEATH_PAUSE, S_GAME_OVER
    } state_t;

    localparam logic [3:0]         LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD = TIMER_W'(PAUSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GO_LOAD    = TIMER_W'(GAMEOVER_CYCLES - 1);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [3:0]         level, level_nxt, best, best_nxt;
    logic               reset_frog, reset_frog_nxt, reset_lives, reset_lives_nxt;
    logic               level_up, level_up_nxt, freeze, freeze_nxt, game_over, game_over_nxt;
    logic               coll_q, restart_q, coll_rise, restart_rise;

    assign coll_rise    = bus.collision_detected & ~coll_q;
    assign restart_rise = bus.restart & ~restart_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            timer       <= '0;
            level       <= 4'd1;
            best        <= 4'd1;
            reset_frog  <= 1'b0;
            reset_lives <= 1'b0;
            level_up    <= 1'b0;
            freeze      <= 1'b0;
            game_over   <= 1'b0;
            coll_q      <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            level       <= level_nxt;
            best        <= best_nxt;
            reset_frog  <= reset_frog_nxt;
            reset_lives <= reset_lives_nxt;
            level_up    <= level_up_nxt;
            freeze      <= freeze_nxt;
            game_over   <= game_over_nxt;
            coll_q      <= bus.collision_detected;
            restart_q   <= bus.restart;
        end
    end

    // While a reset pulse is out, lives/frog_at_top still show pre-reset values,
    // so that cycle ignores them; this also keeps pulses from running back to back.
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        level_nxt       = level;
        best_nxt        = best;
        reset_frog_nxt  = 1'b0;
        reset_lives_nxt = 1'b0;
        level_up_nxt    = 1'b0;
        freeze_nxt      = freeze;
        game_over_nxt   = game_over;
        if (restart_rise) begin
            state_nxt     = S_INIT;
            timer_nxt     = '0;
            freeze_nxt    = 1'b0;
            game_over_nxt = 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state_nxt       = S_PLAY;
                    reset_frog_nxt  = 1'b1;
                    reset_lives_nxt = 1'b1;
                    level_nxt       = 4'd1;
                    freeze_nxt      = 1'b0;
                    game_over_nxt   = 1'b0;
                end
                S_PLAY: begin
                    if (bus.lives == 2'd0 && !reset_lives) begin
                        state_nxt     = S_GAME_OVER;
                        timer_nxt     = GO_LOAD;
                        freeze_nxt    = 1'b1;
                        game_over_nxt = 1'b1;
                    end else if (bus.frog_at_top && !reset_frog) begin
                        state_nxt      = S_LEVEL_PAUSE;
                        timer_nxt      = PAUSE_LOAD;
                        freeze_nxt     = 1'b1;
                        reset_frog_nxt = 1'b1;
                        level_up_nxt   = 1'b1;
                        level_nxt      = (level >= LEVEL_MAX) ? LEVEL_MAX : level + 4'd1;
                        best_nxt       = (level_nxt > best) ? level_nxt : best;
                    end else if (coll_rise) begin
                        state_nxt  = S_DEATH_PAUSE;
                        timer_nxt  = PAUSE_LOAD;
                        freeze_nxt = 1'b1;
                    end
                end
                S_LEVEL_PAUSE, S_DEATH_PAUSE: begin
                    if (timer == '0) begin
                        state_nxt  = S_PLAY;
                        freeze_nxt = 1'b0;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                S_GAME_OVER: begin
                    if (timer == '0) begin
                        state_nxt     = S_INIT;
                        freeze_nxt    = 1'b0;
                        game_over_nxt = 1'b0;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                default: state_nxt = S_INIT;
            endcase
        end
    end

    assign bus.reset_frog  = reset_frog;
    assign bus.reset_lives = reset_lives;
    assign bus.level       = level;
    assign bus.best_level  = best;
    assign bus.level_up    = level_up;
    assign bus.freeze      = freeze;
    assign bus.game_over   = game_over;
endmodule
